// File: rtl/fpu_addsub_pipe.sv
// Three-stage pipelined floating-point add/subtract (align, add, normalise/round/pack).
// Latency 3 cycles, 1 op/cycle; the whole pipe freezes while an output sits unaccepted.
module fpu_addsub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MAN_W:0]     a,
   input  logic [EXP_W+MAN_W:0]     b,
   input  logic                     sub,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     result,
   output logic [3:0]               flags
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int SW  = MAN_W + 4;
   localparam int EW2 = EXP_W + 2;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic adv;
   assign adv      = !(out_valid && !out_ready);
   assign in_ready = adv;

   logic               sa, sb, sx, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap, eop;
   logic [EXP_W-1:0]   ea, eb, ex, ey, d, dsh;
   logic [MAN_W-1:0]   fa, fb;
   logic [SW-1:0]      ext_x, ext_y, my;
   logic [2*SW-1:0]    wide;
   logic               spc;
   logic [W-1:0]       spc_res;
   logic [3:0]         spc_flg;

   always_comb begin
      sa     = a[W-1];
      sb     = b[W-1] ^ sub;
      ea     = a[W-2:MAN_W];
      eb     = b[W-2:MAN_W];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      fa     = a_zero ? '0 : a[MAN_W-1:0];
      fb     = b_zero ? '0 : b[MAN_W-1:0];
      a_nan  = (&ea) && (fa != '0);
      b_nan  = (&eb) && (fb != '0);
      a_inf  = (&ea) && (fa == '0);
      b_inf  = (&eb) && (fb == '0);
      eop    = sa ^ sb;
      swap   = {eb, fb} > {ea, fa};
      sx     = swap ? sb : sa;
      ex     = swap ? eb : ea;
      ey     = swap ? ea : eb;
      ext_x  = swap ? {~b_zero, fb, 3'b000} : {~a_zero, fa, 3'b000};
      ext_y  = swap ? {~a_zero, fa, 3'b000} : {~b_zero, fb, 3'b000};
      d      = ex - ey;
      // Clamp so everything past the field lands in the sticky half of the wide shift.
      dsh    = (d > EXP_W'(SW)) ? EXP_W'(SW) : d;
      wide   = {ext_y, {SW{1'b0}}} >> dsh;
      my     = {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};

      spc     = 1'b1;
      spc_res = '0;
      spc_flg = '0;
      if (a_nan || b_nan || (a_inf && b_inf && eop)) begin
         spc_res = QNAN;
         spc_flg = 4'b1000;
      end else if (a_inf || b_inf) begin
         spc_res = {a_inf ? sa : sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (a_zero && b_zero) begin
         spc_res = {sa & sb, {(W-1){1'b0}}};
      end else begin
         spc = 1'b0;
      end
   end

   logic               s1_vld, s1_eop, s1_sign, s1_spc;
   logic [EXP_W-1:0]   s1_ex;
   logic [SW-1:0]      s1_mx, s1_my;
   logic [W-1:0]       s1_spc_res;
   logic [3:0]         s1_spc_flg;
   logic               s2_vld, s2_sign, s2_spc;
   logic [EXP_W-1:0]   s2_ex;
   logic [SW:0]        s2_sum;
   logic [W-1:0]       s2_spc_res;
   logic [3:0]         s2_spc_flg;

   logic [EW2-1:0]     lz, ne, re;
   logic [SW-1:0]      norm;
   logic [MAN_W+1:0]   mant;
   logic [MAN_W-1:0]   frac;
   logic               rnd_up, inx;
   logic [W-1:0]       res_n;
   logic [3:0]         flg_n;

   always_comb begin
      lz = '0;
      for (int i = 0; i < SW; i++)
         if (s2_sum[i]) lz = EW2'(SW - 1 - i);
      if (s2_sum[SW]) begin
         norm = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
         ne   = {2'b00, s2_ex} + EW2'(1);
      end else begin
         norm = s2_sum[SW-1:0] << lz;
         ne   = {2'b00, s2_ex} - lz;
      end
      inx    = |norm[2:0];
      rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant   = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
      // A rounding carry leaves 1.000..0, so the stored fraction is zero either way.
      re     = ne + {{(EW2-1){1'b0}}, mant[MAN_W+1]};
      frac   = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];

      res_n = '0;
      flg_n = '0;
      if (s2_spc) begin
         res_n = s2_spc_res;
         flg_n = s2_spc_flg;
      end else if (s2_sum == '0) begin
         res_n = '0;
      end else if (ne[EW2-1] || ne == '0) begin
         res_n = {s2_sign, {(W-1){1'b0}}};
         flg_n = 4'b0011;
      end else if (re >= {2'b00, {EXP_W{1'b1}}}) begin
         res_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flg_n = 4'b0101;
      end else begin
         res_n = {s2_sign, re[EXP_W-1:0], frac};
         flg_n = {3'b000, inx};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld    <= 1'b0;
         s2_vld    <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else if (adv) begin
         s1_vld    <= in_valid;
         s2_vld    <= s1_vld;
         out_valid <= s2_vld;
         if (s2_vld) begin
            result <= res_n;
            flags  <= flg_n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         s1_eop     <= eop;
         s1_sign    <= sx;
         s1_ex      <= ex;
         s1_mx      <= ext_x;
         s1_my      <= my;
         s1_spc     <= spc;
         s1_spc_res <= spc_res;
         s1_spc_flg <= spc_flg;
         s2_sign    <= s1_sign;
         s2_ex      <= s1_ex;
         s2_sum     <= s1_eop ? ({1'b0, s1_mx} - {1'b0, s1_my}) : ({1'b0, s1_mx} + {1'b0, s1_my});
         s2_spc     <= s1_spc;
         s2_spc_res <= s1_spc_res;
         s2_spc_flg <= s1_spc_flg;
      end
   end
endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Scoreboard bench for fpu_addsub_pipe: single-precision instance plus a half-precision instance.
module tb_fpu_addsub_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, sub = 1'b0, out_valid, out_ready = 1'b1;
   logic [31:0] a = '0, b = '0, result;
   logic [3:0]  flags;
   logic        h_in_valid = 1'b0, h_in_ready, h_sub = 1'b0, h_out_valid, h_out_ready = 1'b1;
   logic [15:0] h_a = '0, h_b = '0, h_result;
   logic [3:0]  h_flags;

   always #5 clk = ~clk;

   fpu_addsub_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags));

   fpu_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b), .sub(h_sub),
      .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result), .flags(h_flags));

   typedef struct { logic [31:0] r; logic [3:0] f; int acc; bit lat; } exp_t;
   exp_t sbq[$];
   int   n_vec = 0, n_err = 0, cyc = 0, n_out = 0, stall_start = -1;
   bit   chk_lat = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, got, want);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      out_ready = !(stall_start >= 0 && cyc >= stall_start && cyc < stall_start + 4);
   end

   // Output monitor: hold checks while stalled, scoreboard pop on each transfer.
   initial begin
      bit          prev_stall = 1'b0;
      logic [31:0] prev_res = '0;
      logic [3:0]  prev_flg = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
            continue;
         end
         if (prev_stall) begin
            check("hold_vld", out_valid, 1);
            check("hold_res", result, prev_res);
            check("hold_flg", flags, prev_flg);
         end
         if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
         prev_stall = out_valid && !out_ready;
         prev_res   = result;
         prev_flg   = flags;
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               check("spurious_out", out_valid, 0);
            end else begin
               e = sbq.pop_front();
               check("result", result, e.r);
               check("flags", flags, e.f);
               if (e.lat) check("latency", cyc - e.acc, 3);
               n_out++;
            end
         end
      end
   end

   task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                       input logic [31:0] er, input logic [3:0] ef);
      exp_t e;
      a = ta; b = tb_; sub = ts; in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) break;
         @(posedge clk);
         #1;
      end
      if (!in_ready) begin
         check("accept_timeout", in_ready, 1);
      end else begin
         e.r = er; e.f = ef; e.acc = cyc; e.lat = chk_lat;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int k = 0; k < 100 && sbq.size() != 0; k++) @(posedge clk);
      check("drain", sbq.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic hop(input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] er, input logic [3:0] ef);
      int k;
      h_a = ta; h_b = tb_; h_in_valid = 1'b1;
      @(negedge clk);
      check("h_in_ready", h_in_ready, 1);
      @(posedge clk);
      #1;
      h_in_valid = 1'b0;
      for (k = 0; k < 10; k++) begin
         @(negedge clk);
         if (h_out_valid) break;
      end
      check("h_vld", h_out_valid, 1);
      check("h_lat", k, 2);
      check("h_res", h_result, er);
      check("h_flg", h_flags, ef);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_flags", flags, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Back-to-back directed vectors, full throughput.
      send(32'h3F800000, 32'h40000000, 0, 32'h40400000, 4'b0000);
      send(32'h3F800000, 32'h3F800000, 1, 32'h00000000, 4'b0000);
      send(32'h80000000, 32'h80000000, 0, 32'h80000000, 4'b0000);
      send(32'h3F800001, 32'h33800000, 0, 32'h3F800002, 4'b0001);
      send(32'h3F800000, 32'h33800000, 0, 32'h3F800000, 4'b0001);
      send(32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 4'b0101);
      send(32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 4'b1000);
      send(32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, 4'b1000);
      send(32'h3FC00000, 32'h3FA00000, 1, 32'h3E800000, 4'b0000);
      send(32'h3F800000, 32'h40000000, 1, 32'hBF800000, 4'b0000);
      send(32'h00800000, 32'h00C00000, 1, 32'h80000000, 4'b0011);
      send(32'hFF800000, 32'h3F800000, 0, 32'hFF800000, 4'b0000);
      send(32'h3F800000, 32'h7F800000, 1, 32'hFF800000, 4'b0000);
      send(32'h80000000, 32'h00000000, 1, 32'h80000000, 4'b0000);
      send(32'h3F800000, 32'h00800000, 0, 32'h3F800000, 4'b0001);
      send(32'h00000001, 32'h00000000, 0, 32'h00000000, 4'b0000);
      drain();

      // Backpressure: out_ready low for 4 cycles in the middle of a 6-op stream.
      chk_lat = 1'b0;
      n_out = 0;
      stall_start = cyc + 4;
      send(32'h3F800000, 32'h3F800000, 0, 32'h40000000, 4'b0000);
      send(32'h3F800000, 32'h40000000, 0, 32'h40400000, 4'b0000);
      send(32'h3F800000, 32'h40400000, 0, 32'h40800000, 4'b0000);
      send(32'h3F800000, 32'h40800000, 0, 32'h40A00000, 4'b0000);
      send(32'h3F800000, 32'h40A00000, 0, 32'h40C00000, 4'b0000);
      send(32'h3F800000, 32'h40C00000, 0, 32'h40E00000, 4'b0000);
      drain();
      check("bp_count", n_out, 6);
      stall_start = -1;
      chk_lat = 1'b1;

      // Reset with three operations in flight.
      send(32'h3F800000, 32'h3F800000, 0, 32'h40000000, 4'b0000);
      send(32'h3F800000, 32'h40000000, 0, 32'h40400000, 4'b0000);
      send(32'h3F800000, 32'h40400000, 0, 32'h40800000, 4'b0000);
      in_valid = 1'b0;
      rst = 1'b1;
      sbq.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      for (int k = 0; k < 6; k++) begin
         check("post_rst_out_valid", out_valid, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      send(32'h40000000, 32'h3F800000, 1, 32'h3F800000, 4'b0000);
      drain();

      // Half-precision instance.
      hop(16'h3C00, 16'h3C00, 16'h4000, 4'b0000);
      hop(16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
